// File: rtl/qupls_wb_arbiter.sv
// Writeback arbiter: buffers functional-unit results in per-source skid FIFOs and
// round-robins the FIFO heads onto NWB registered ROB writeback ports.
module qupls_wb_arbiter #(
  parameter int unsigned NSRC  = 7,
  parameter int unsigned NWB   = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RNDXW = 5,
  parameter int unsigned DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NSRC-1:0]        src_v,
  input  logic [NSRC*RNDXW-1:0]  src_rndx,
  input  logic [NSRC*DW-1:0]     src_res,
  input  logic [NSRC*8-1:0]      src_exc,
  output logic [NSRC-1:0]        src_rdy,
  output logic [NWB-1:0]         wb_v,
  output logic [NWB*RNDXW-1:0]   wb_rndx,
  output logic [NWB*DW-1:0]      wb_res,
  output logic [NWB*8-1:0]       wb_exc,
  output logic [NWB*3-1:0]       wb_src,
  output logic [15:0]            stall_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned EW = RNDXW + DW + 8;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [RW:0]   NsrcC  = (RW + 1)'(NSRC);

  typedef logic [EW-1:0] entry_t;

  entry_t        mem_q    [NSRC][DEPTH];
  logic [PW-1:0] wr_ptr_q [NSRC];
  logic [PW-1:0] rd_ptr_q [NSRC];
  logic [CW-1:0] count_q  [NSRC];
  logic [CW-1:0] count_d  [NSRC];
  logic [RW-1:0] rr_ptr_q;
  logic [RW-1:0] rr_ptr_d;

  entry_t          src_ent [NSRC];
  entry_t          head    [NSRC];
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] rot;
  logic [NSRC-1:0] taken;

  logic [NWB-1:0] gnt_v;
  logic [RW-1:0]  gnt_off [NWB];
  logic [RW:0]    gnt_sum [NWB];
  logic [RW-1:0]  gnt_src [NWB];
  entry_t         gnt_ent [NWB];

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      src_ent[s]  = {src_rndx[s*RNDXW +: RNDXW], src_res[s*DW +: DW], src_exc[s*8 +: 8]};
      head[s]     = mem_q[s][rd_ptr_q[s]];
      nonempty[s] = (count_q[s] != '0);
      push[s]     = src_v[s] & src_rdy[s] & ~flush;
    end
  end

  // Rotate occupancy so bit 0 is the source at rr_ptr; grants are then offsets in scan order.
  always_comb begin
    rot   = NSRC'({nonempty, nonempty} >> rr_ptr_q);
    taken = '0;
    gnt_v = '0;
    for (int k = 0; k < NWB; k++) begin
      gnt_off[k] = '0;
      for (int i = 0; i < NSRC; i++) begin
        if (!gnt_v[k] && rot[i] && !taken[i]) begin
          gnt_v[k]   = 1'b1;
          gnt_off[k] = RW'(i);
          taken[i]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NWB; k++) begin
      gnt_sum[k] = {1'b0, rr_ptr_q} + {1'b0, gnt_off[k]};
      if (gnt_sum[k] >= NsrcC) begin
        gnt_sum[k] = gnt_sum[k] - NsrcC;
      end
      gnt_src[k] = gnt_sum[k][RW-1:0];
      gnt_ent[k] = '0;
      for (int s = 0; s < NSRC; s++) begin
        if (gnt_v[k] && gnt_src[k] == RW'(s)) begin
          pop[s]     = 1'b1;
          gnt_ent[k] = head[s];
        end
      end
      // Ports fill in scan order, so the highest valid port holds the last granted source.
      if (gnt_v[k]) begin
        rr_ptr_d = (gnt_src[k] == RW'(NSRC - 1)) ? '0 : gnt_src[k] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      case ({push[s], pop[s]})
        2'b10:   count_d[s] = count_q[s] + 1'b1;
        2'b01:   count_d[s] = count_q[s] - 1'b1;
        default: count_d[s] = count_q[s];
      endcase
    end
  end

  // Storage is not reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s]] <= src_ent[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_ptr_q  <= '0;
      src_rdy   <= '1;
      wb_v      <= '0;
      wb_rndx   <= '0;
      wb_res    <= '0;
      wb_exc    <= '0;
      wb_src    <= '0;
      stall_cnt <= '0;
    end else begin
      if (!(&src_rdy) && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush) begin
        for (int s = 0; s < NSRC; s++) begin
          wr_ptr_q[s] <= '0;
          rd_ptr_q[s] <= '0;
          count_q[s]  <= '0;
        end
        rr_ptr_q <= '0;
        src_rdy  <= '1;
        wb_v     <= '0;
      end else begin
        for (int s = 0; s < NSRC; s++) begin
          if (push[s]) begin
            wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
          end
          if (pop[s]) begin
            rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
          end
          count_q[s] <= count_d[s];
          // Registered ready ignores a same-cycle pop into a full FIFO.
          src_rdy[s] <= (count_d[s] < DepthC);
        end
        rr_ptr_q <= rr_ptr_d;
        for (int k = 0; k < NWB; k++) begin
          wb_v[k] <= gnt_v[k];
          if (gnt_v[k]) begin
            wb_rndx[k*RNDXW +: RNDXW] <= gnt_ent[k][EW-1 -: RNDXW];
            wb_res[k*DW +: DW]        <= gnt_ent[k][8 +: DW];
            wb_exc[k*8 +: 8]          <= gnt_ent[k][7:0];
            wb_src[k*3 +: 3]          <= 3'(gnt_src[k]);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_occ_chk
    assert property (@(posedge clk) disable iff (rst) count_q[g] <= DepthC);
  end

endmodule

// File: tb/tb_qupls_wb_arbiter.sv
// Randomized bench for qupls_wb_arbiter: per-source queues model the FIFOs and a
// modulo round-robin scan predicts every writeback port each cycle.
module tb_qupls_wb_arbiter;

  localparam int NSRC  = 7;
  localparam int NWB   = 2;
  localparam int DEPTH = 2;
  localparam int RNDXW = 5;
  localparam int DW    = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [NSRC-1:0]       src_v;
  logic [NSRC*RNDXW-1:0] src_rndx;
  logic [NSRC*DW-1:0]    src_res;
  logic [NSRC*8-1:0]     src_exc;
  logic [NSRC-1:0]       src_rdy;
  logic [NWB-1:0]        wb_v;
  logic [NWB*RNDXW-1:0]  wb_rndx;
  logic [NWB*DW-1:0]     wb_res;
  logic [NWB*8-1:0]      wb_exc;
  logic [NWB*3-1:0]      wb_src;
  logic [15:0]           stall_cnt;

  qupls_wb_arbiter #(
    .NSRC(NSRC), .NWB(NWB), .DEPTH(DEPTH), .RNDXW(RNDXW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_v(src_v), .src_rndx(src_rndx), .src_res(src_res), .src_exc(src_exc),
    .src_rdy(src_rdy),
    .wb_v(wb_v), .wb_rndx(wb_rndx), .wb_res(wb_res), .wb_exc(wb_exc), .wb_src(wb_src),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RNDXW-1:0] rndx;
    logic [DW-1:0]    res;
    logic [7:0]       exc;
  } ent_t;

  ent_t            mq [NSRC][$];
  int              m_rr;
  logic [NSRC-1:0] m_rdy;
  int              m_stall;
  logic            m_full;
  logic [NWB-1:0]  e_v;
  ent_t            e_ent [NWB];
  int              e_src [NWB];

  ent_t            pend [NSRC];
  logic [NSRC-1:0] pend_v;
  int              serial;
  int              n_chk;
  int              n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    src_v = pend_v;
    for (int s = 0; s < NSRC; s++) begin
      src_rndx[s*RNDXW +: RNDXW] = pend[s].rndx;
      src_res[s*DW +: DW]        = pend[s].res;
      src_exc[s*8 +: 8]          = pend[s].exc;
    end
  endtask

  task automatic gen(input logic [NSRC-1:0] mask, input int rate);
    for (int s = 0; s < NSRC; s++) begin
      if (mask[s] && !pend_v[s] && $urandom_range(99) < rate) begin
        pend_v[s]    = 1'b1;
        pend[s].rndx = RNDXW'($urandom);
        pend[s].res  = {8'(s), 24'h0, 32'(serial)};
        pend[s].exc  = ($urandom_range(7) == 0) ? 8'($urandom) : 8'h0;
        serial++;
      end
    end
  endtask

  // Reference: pop up to NWB heads in modulo scan order, then accept ready pushes.
  task automatic model_step();
    int ng;
    int last;
    int s;
    m_full = rst;
    e_v    = '0;
    if (rst) begin
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      for (int k = 0; k < NWB; k++) begin
        e_ent[k] = '0;
        e_src[k] = 0;
      end
      m_rr    = 0;
      m_rdy   = '1;
      m_stall = 0;
      pend_v  = '0;
      return;
    end
    if (m_rdy != '1 && m_stall < 65535) m_stall++;
    if (flush) begin
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      m_rr   = 0;
      m_rdy  = '1;
      pend_v = '0;
      return;
    end
    ng   = 0;
    last = -1;
    for (int i = 0; i < NSRC; i++) begin
      s = (m_rr + i) % NSRC;
      if (mq[s].size() > 0 && ng < NWB) begin
        e_v[ng]   = 1'b1;
        e_ent[ng] = mq[s].pop_front();
        e_src[ng] = s;
        ng++;
        last = s;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (src_v[i] && m_rdy[i]) begin
        mq[i].push_back(pend[i]);
        pend_v[i] = 1'b0;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NSRC;
    for (int i = 0; i < NSRC; i++) m_rdy[i] = (mq[i].size() < DEPTH);
  endtask

  task automatic compare();
    check("src_rdy", 64'(src_rdy), 64'(m_rdy));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("wb_v", 64'(wb_v), 64'(e_v));
    for (int k = 0; k < NWB; k++) begin
      if (e_v[k] || m_full) begin
        check($sformatf("wb_rndx%0d", k), 64'(wb_rndx[k*RNDXW +: RNDXW]), 64'(e_ent[k].rndx));
        check($sformatf("wb_res%0d", k), wb_res[k*DW +: DW], e_ent[k].res);
        check($sformatf("wb_exc%0d", k), 64'(wb_exc[k*8 +: 8]), 64'(e_ent[k].exc));
        check($sformatf("wb_src%0d", k), 64'(wb_src[k*3 +: 3]), 64'(e_src[k]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  int exp_s0 [4] = '{0, 2, 4, 6};
  int exp_s1 [4] = '{1, 3, 5, 0};
  int exp_v  [4] = '{3, 3, 3, 1};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    serial = 0;
    pend_v = '0;
    for (int s = 0; s < NSRC; s++) pend[s] = '0;
    rst   = 1'b1;
    flush = 1'b0;
    apply();
    step();
    step();
    rst = 1'b0;

    // Single result from source 0
    pend[0]   = '{rndx: 5'd5, res: 64'hDEAD, exc: 8'h0};
    pend_v[0] = 1'b1;
    apply();
    step();
    apply();
    step();
    check("single_v", 64'(wb_v), 64'h1);
    check("single_rndx", 64'(wb_rndx[RNDXW-1:0]), 64'd5);
    check("single_res", wb_res[DW-1:0], 64'hDEAD);
    check("single_src", 64'(wb_src[2:0]), 64'd0);

    // Flush returns rr_ptr to 0, then every source fires once
    flush = 1'b1;
    apply();
    step();
    flush = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      pend[s]   = '{rndx: 5'(s + 10), res: 64'(s), exc: 8'h0};
      pend_v[s] = 1'b1;
    end
    apply();
    step();
    for (int c = 0; c < 4; c++) begin
      apply();
      step();
      check("all7_v", 64'(wb_v), 64'(exp_v[c]));
      check("all7_src0", 64'(wb_src[2:0]), 64'(exp_s0[c]));
      check("all7_rndx0", 64'(wb_rndx[RNDXW-1:0]), 64'(exp_s0[c] + 10));
      if (exp_v[c] == 3) check("all7_src1", 64'(wb_src[5:3]), 64'(exp_s1[c]));
    end
    apply();
    step();
    check("all7_idle", 64'(wb_v), 64'h0);

    // Saturate sources 0..3 to force backpressure
    for (int c = 0; c < 16; c++) begin
      gen(7'h0F, 100);
      apply();
      step();
    end
    check("stall_grew", 64'(stall_cnt != 16'h0), 64'h1);

    // Reset with FIFOs loaded
    rst = 1'b1;
    apply();
    step();
    rst = 1'b0;

    // Fairness between sources 0 and 6
    for (int c = 0; c < 20; c++) begin
      gen(7'h41, 100);
      apply();
      step();
    end

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      gen(7'h7F, 20 + 10 * (c % 8));
      flush = ($urandom_range(24) == 0);
      rst   = ($urandom_range(79) == 0);
      apply();
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      apply();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
